inst_fetch_ctrl: RTL and testbench
==================================

Name: inst_fetch_ctrl

Overview:
Instruction-fetch sequencer in front of the combinational instruction ROM. It owns the PC and drives the ROM chip-enable and address. It captures each returned word with its PC into a small prefetch FIFO and hands entries to decode through a valid/ready handshake. Branch redirects flush the FIFO and reload the PC. Sits between the ROM and the IF/ID pipeline register.

Parameters:
ADDR_W, 32, PC / ROM address width in bits
INST_W, 32, instruction word width
DEPTH, 2, prefetch FIFO entries (power of two, >=2)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous reset, active-high
fetch_en  in  1  1 = fetching allowed; 0 = hold PC, FIFO still drains
br_taken  in  1  redirect request, single-cycle pulse
br_target  in  ADDR_W  redirect PC; bits [1:0] forced to 0
rom_ce  out  1  ROM chip enable (ENABLE = 1)
rom_addr  out  ADDR_W  ROM address = current PC
rom_inst  in  INST_W  ROM data, valid in the same cycle as rom_ce
if_valid  out  1  head entry available to decode
if_pc  out  ADDR_W  PC of head entry
if_inst  out  INST_W  instruction of head entry
id_ready  in  1  decode accepts head this cycle

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, FIFO count=0, read/write pointers=0, state=IDLE. During reset and the first cycle after it: rom_ce=0, if_valid=0, if_pc=0, if_inst=0 (ZERO_WORD when empty).
- Reset has priority over every other input. Reset mid-operation discards all FIFO contents and any redirect.
- States: IDLE (no fetch), FETCH (issuing). IDLE->FETCH when fetch_en=1. FETCH->IDLE when fetch_en=0. A branch does not change state.
- push = (state==FETCH) && !br_taken && (count<DEPTH || pop).
- rom_ce = push. rom_addr = pc at all times. rom_ce=0 whenever no push happens.
- On push: write {pc, rom_inst} into the FIFO tail, then pc <= pc+4 (modulo 2^ADDR_W; 0xFFFFFFFC wraps to 0).
- Fetch-to-output latency is 1 cycle: a word fetched in cycle N appears on if_* in cycle N+1 at the earliest.
- if_valid = (count!=0) && !br_taken. if_pc and if_inst are driven combinationally from the FIFO head. When empty they read 0.
- pop = if_valid && id_ready. On pop, the read pointer advances.
- Full with a simultaneous pop: push is allowed and count is unchanged. Empty with a push: count goes to 1 and nothing pops that cycle.
- br_taken=1: at the edge, FIFO is cleared (count and pointers set to 0) and pc <= {br_target[ADDR_W-1:2],2'b00}. No push or pop occurs that cycle. The first fetch from the target is issued the next cycle if state==FETCH.
- Back-to-back br_taken: the last target wins. No fetch occurs until br_taken is low.
- fetch_en=0 during a branch: pc is still redirected and the FIFO still flushed.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH and never overflows or underflows.

Decomposition:
- Shared `define header: ENABLE/DISABLE, ZERO_WORD, INST_ADDR_BUS, INST_BUS, PC increment constant (4), and state encodings IDLE=1'b0, FETCH=1'b1.
- One sub-module, fetch_fifo: synchronous FIFO of {pc, inst} with push, pop, flush, count, and a combinational head. inst_fetch_ctrl holds the PC, the FSM, and the push/pop/redirect logic.

Test Plan:
- Reset then fetch_en=1, id_ready=1, ROM word at addr k = k: rom_ce rises 1 cycle after reset. if_valid starts 1 cycle later with if_pc=0/if_inst=0, then 4/4 and 8/8, one per cycle.
- id_ready=0 for 5 cycles while fetching: after 2 fetches (PC 0, 4), rom_ce=0 and pc holds at 8. Raise id_ready: pops PC 0 and 4 in order, and push resumes in the same cycle as the first pop.
- Branch to 0x40 while FIFO holds 2 entries: if_valid=0 in the branch cycle and the next cycle. Next valid entry is if_pc=0x40, with no stale entries.
- Branch to 0x43: pc becomes 0x40. A branch and a pop in the same cycle: the pop is suppressed and count is 0 afterwards.
- Branch to 0xFFFFFFFC, id_ready=1: if_pc sequence is 0xFFFFFFFC, then 0x00000000.
- rst asserted for 1 cycle with 2 entries queued and fetch_en=1: all outputs are 0 next cycle. Fetch restarts at RESET_PC and no pre-reset entry appears.

Source files
------------

// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared constants and FSM encoding for the instruction-fetch sequencer.
package inst_fetch_ctrl_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam int INST_ADDR_BUS = 32;
  localparam int INST_BUS      = 32;
  localparam int PC_STEP       = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_ctrl_fetch_fifo.sv
// Prefetch FIFO of {pc, inst} pairs; head is presented combinationally and reads 0 when empty.
module fetch_fifo #(
  parameter int AW    = 32,
  parameter int IW    = 32,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [AW-1:0]    wpc,
  input  logic [IW-1:0]    winst,
  output logic [CNT_W-1:0] count,
  output logic [AW-1:0]    head_pc,
  output logic [IW-1:0]    head_inst
);

  logic [AW-1:0]    pc_mem   [DEPTH];
  logic [IW-1:0]    inst_mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;

  always_ff @(posedge clk) begin
    if (push && !flush && !rst) begin
      pc_mem[wptr]   <= wpc;
      inst_mem[wptr] <= winst;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_pc   = (count != '0) ? pc_mem[rptr]   : '0;
  assign head_inst = (count != '0) ? inst_mem[rptr] : '0;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the ROM and feeds decode from a prefetch FIFO.
// Decode handshake: an entry transfers on a cycle where if_valid && id_ready at the rising edge.
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = INST_ADDR_BUS,
  parameter int                INST_W   = INST_BUS,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_inst,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0] if_inst,
  input  logic              id_ready,
  output fetch_state_e      dbg_state
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e      state;
  fetch_state_e      state_next;
  logic [ADDR_W-1:0] pc;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fetch_en)  state_next = FETCH;
      FETCH:   if (!fetch_en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A redirect hides the head and blocks both push and pop for that cycle.
  assign if_valid = (count != '0) && !br_taken;
  assign pop      = if_valid && id_ready;
  assign push     = (state == FETCH) && !br_taken && ((count < CNT_W'(DEPTH)) || pop);

  assign rom_ce    = push ? ENABLE : DISABLE;
  assign rom_addr  = pc;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst)           pc <= RESET_PC;
    else if (br_taken) pc <= br_target & ~ADDR_W'(3);
    else if (push)     pc <= pc + ADDR_W'(PC_STEP);
  end

  fetch_fifo #(
    .AW    (ADDR_W),
    .IW    (INST_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (br_taken),
    .wpc       (pc),
    .winst     (rom_inst),
    .count     (count),
    .head_pc   (if_pc),
    .head_inst (if_inst)
  );

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl; ROM model returns the word address as the instruction.
module tb_inst_fetch_ctrl;
  import inst_fetch_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        br_taken;
  logic [31:0] br_target;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        id_ready;
  fetch_state_e dbg_state;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign rom_inst = rom_addr;

  inst_fetch_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .fetch_en  (fetch_en),
    .br_taken  (br_taken),
    .br_target (br_target),
    .rom_ce    (rom_ce),
    .rom_addr  (rom_addr),
    .rom_inst  (rom_inst),
    .if_valid  (if_valid),
    .if_pc     (if_pc),
    .if_inst   (if_inst),
    .id_ready  (id_ready),
    .dbg_state (dbg_state)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] exp_pc);
    chk({tag, "_valid"}, 32'(if_valid), 32'd1);
    chk({tag, "_pc"}, if_pc, exp_pc);
    chk({tag, "_inst"}, if_inst, exp_pc);
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b0; br_taken = 1'b0; br_target = '0; id_ready = 1'b0;
    next_cycle();
    next_cycle();
    #1;
    chk("rst_rom_ce", 32'(rom_ce), 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_inst", if_inst, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));

    // Straight-line fetch with decode always ready
    rst = 1'b0; fetch_en = 1'b1; id_ready = 1'b1;
    #1;
    chk("post_rst_rom_ce", 32'(rom_ce), 32'd0);
    chk("post_rst_if_valid", 32'(if_valid), 32'd0);
    next_cycle();
    chk("f0_rom_ce", 32'(rom_ce), 32'd1);
    chk("f0_rom_addr", rom_addr, 32'h0);
    chk("f0_if_valid", 32'(if_valid), 32'd0);
    chk("f0_state", 32'(dbg_state), 32'(FETCH));
    next_cycle();
    chk_head("seq0", 32'h0);
    chk("seq0_rom_addr", rom_addr, 32'h4);
    next_cycle();
    chk_head("seq1", 32'h4);
    next_cycle();
    chk_head("seq2", 32'h8);

    // Decode stalls: FIFO fills with 8 and 12, then fetch holds at 16
    id_ready = 1'b0;
    #1;
    chk("stall0_rom_ce", 32'(rom_ce), 32'd1);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      chk("stall_rom_ce", 32'(rom_ce), 32'd0);
      chk("stall_rom_addr", rom_addr, 32'h10);
      chk_head("stall_head", 32'h8);
    end
    id_ready = 1'b1;
    #1;
    chk("resume_rom_ce", 32'(rom_ce), 32'd1);
    chk("resume_rom_addr", rom_addr, 32'h10);
    next_cycle();
    chk_head("resume1", 32'hC);
    chk("resume1_rom_addr", rom_addr, 32'h14);

    // Redirect to 0x40 while FIFO holds 12 and 16, with a pop requested
    br_taken = 1'b1; br_target = 32'h40;
    #1;
    chk("br40_if_valid", 32'(if_valid), 32'd0);
    chk("br40_rom_ce", 32'(rom_ce), 32'd0);
    next_cycle();
    br_taken = 1'b0;
    #1;
    chk("br40_n1_if_valid", 32'(if_valid), 32'd0);
    chk("br40_n1_rom_ce", 32'(rom_ce), 32'd1);
    chk("br40_n1_rom_addr", rom_addr, 32'h40);
    next_cycle();
    chk_head("br40_first", 32'h40);
    next_cycle();
    chk_head("br40_second", 32'h44);

    // Misaligned target is forced to a word boundary
    br_taken = 1'b1; br_target = 32'h43;
    #1;
    chk("br43_if_valid", 32'(if_valid), 32'd0);
    next_cycle();
    br_taken = 1'b0;
    #1;
    chk("br43_rom_addr", rom_addr, 32'h40);
    chk("br43_if_valid_after", 32'(if_valid), 32'd0);
    next_cycle();
    chk_head("br43_first", 32'h40);

    // Back-to-back redirects: last target wins, no fetch while br_taken high
    br_taken = 1'b1; br_target = 32'h100;
    #1;
    chk("b2b0_rom_ce", 32'(rom_ce), 32'd0);
    next_cycle();
    br_target = 32'h200;
    #1;
    chk("b2b1_rom_ce", 32'(rom_ce), 32'd0);
    chk("b2b1_rom_addr", rom_addr, 32'h100);
    next_cycle();
    br_taken = 1'b0;
    #1;
    chk("b2b_rom_addr", rom_addr, 32'h200);
    chk("b2b_if_valid", 32'(if_valid), 32'd0);
    next_cycle();
    chk_head("b2b_first", 32'h200);

    // PC wraps from the top of the address space
    br_taken = 1'b1; br_target = 32'hFFFF_FFFC;
    next_cycle();
    br_taken = 1'b0;
    #1;
    chk("wrap_rom_addr", rom_addr, 32'hFFFF_FFFC);
    next_cycle();
    chk_head("wrap_top", 32'hFFFF_FFFC);
    chk("wrap_rom_addr2", rom_addr, 32'h0);
    next_cycle();
    chk_head("wrap_zero", 32'h0);

    // Redirect still applies while fetch is being disabled
    fetch_en = 1'b0; br_taken = 1'b1; br_target = 32'h80;
    next_cycle();
    br_taken = 1'b0;
    #1;
    chk("fen0_rom_ce", 32'(rom_ce), 32'd0);
    chk("fen0_rom_addr", rom_addr, 32'h80);
    chk("fen0_if_valid", 32'(if_valid), 32'd0);
    chk("fen0_state", 32'(dbg_state), 32'(IDLE));
    next_cycle();
    chk("fen0_hold_rom_ce", 32'(rom_ce), 32'd0);
    chk("fen0_hold_rom_addr", rom_addr, 32'h80);

    // Queue two entries, then reset mid-operation
    fetch_en = 1'b1; id_ready = 1'b0;
    next_cycle();
    chk("refill_rom_addr", rom_addr, 32'h80);
    chk("refill_rom_ce", 32'(rom_ce), 32'd1);
    next_cycle();
    next_cycle();
    chk("full_rom_ce", 32'(rom_ce), 32'd0);
    chk_head("full_head", 32'h80);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0; id_ready = 1'b1;
    #1;
    chk("mid_rst_rom_ce", 32'(rom_ce), 32'd0);
    chk("mid_rst_if_valid", 32'(if_valid), 32'd0);
    chk("mid_rst_if_pc", if_pc, 32'd0);
    chk("mid_rst_if_inst", if_inst, 32'd0);
    chk("mid_rst_rom_addr", rom_addr, 32'd0);
    next_cycle();
    chk("restart_rom_ce", 32'(rom_ce), 32'd1);
    chk("restart_rom_addr", rom_addr, 32'h0);
    chk("restart_if_valid", 32'(if_valid), 32'd0);
    next_cycle();
    chk_head("restart_first", 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
